// File: rtl/rf_pkg.sv
// Shared sizing for the scoreboarded register file.
// Holds default widths and the busy-count width helper; no logic.
// Nothing here is clocked and nothing can stall.
package rf_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  // Every register may be busy at once, so the count needs one bit more than an address.
  function automatic int cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard with a registered population count.
// Busy bits and count update on the clock edge; outputs show registered state only.
// Never stalls: reserve and clear are accepted every cycle.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rsv,
  input  logic [ADDR_W-1:0]         rsv_addr,
  input  logic                      clr,
  input  logic [ADDR_W-1:0]         clr_addr,
  input  logic [ADDR_W-1:0]         rs,
  input  logic [ADDR_W-1:0]         rt,
  output logic                      busy1,
  output logic                      busy2,
  output logic [cnt_w(ADDR_W)-1:0]  busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = cnt_w(ADDR_W);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             set_en, clr_en, inc, dec;

  always_comb begin
    set_en = rsv && !(ZERO_R0 && (rsv_addr == '0));
    clr_en = clr && !(ZERO_R0 && (clr_addr == '0));

    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[rsv_addr] = 1'b1;

    // Count only real transitions so a set on a busy bit or a clear on an idle bit is net zero.
    inc   = set_en && !busy_q[rsv_addr];
    dec   = clr_en && busy_q[clr_addr] && !(set_en && (rsv_addr == clr_addr));
    cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy1    = busy_q[rs];
  assign busy2    = busy_q[rt];
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read, two-write register file with optional write-to-read forwarding and a busy scoreboard.
// Reads are combinational (zero latency); writes commit on the rising edge.
// No backpressure: every read, write and reserve is taken in the cycle it is presented.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         rs,
  input  logic [ADDR_W-1:0]         rt,
  input  logic [ADDR_W-1:0]         rd,
  input  logic [DATA_W-1:0]         rw,
  input  logic                      wr,
  input  logic [ADDR_W-1:0]         rd2,
  input  logic [DATA_W-1:0]         rw2,
  input  logic                      wr2,
  input  logic                      rsv,
  input  logic [ADDR_W-1:0]         rsv_addr,
  output logic [DATA_W-1:0]         rout1,
  output logic [DATA_W-1:0]         rout2,
  output logic                      busy1,
  output logic                      busy2,
  output logic [cnt_w(ADDR_W)-1:0]  busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              wr_en, wr2_en;

  always_comb begin
    wr_en  = wr  && !(ZERO_R0 && (rd  == '0));
    wr2_en = wr2 && !(ZERO_R0 && (rd2 == '0));
    regs_d = regs_q;
    if (wr_en)  regs_d[rd]  = rw;
    // Load-return port is applied last so it wins an address collision.
    if (wr2_en) regs_d[rd2] = rw2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Forwarding is gated by rst so a write presented during reset never leaks to the outputs.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] val;
    val = regs_q[a];
    if (BYPASS && rst) begin
      if (wr2_en && (rd2 == a))     val = rw2;
      else if (wr_en && (rd == a))  val = rw;
    end
    if (ZERO_R0 && (a == '0)) val = '0;
    return val;
  endfunction

  assign rout1 = read_port(rs);
  assign rout2 = read_port(rt);

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .rsv      (rsv),
    .rsv_addr (rsv_addr),
    .clr      (wr2),
    .clr_addr (rd2),
    .rs       (rs),
    .rt       (rt),
    .busy1    (busy1),
    .busy2    (busy2),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, register address width (depth 2**ADDR_W).
REQ-003 The block SHALL have parameter ZERO_R0, default 1; when 1, register 0 reads as zero and ignores writes.
REQ-004 The block SHALL have parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to read ports.
REQ-005 The block SHALL have port clk  input  1  single clock, rising edge.
REQ-006 The block SHALL have port rst  input  1  asynchronous active-low reset.
REQ-007 The block SHALL have ports rs, rt  input  ADDR_W  read addresses, port A and port B.
REQ-008 The block SHALL have ports rd, rw, wr  input  ADDR_W/DATA_W/1  primary write address, data, enable (ALU port).
REQ-009 The block SHALL have ports rd2, rw2, wr2  input  ADDR_W/DATA_W/1  secondary write address, data, enable (load-return port).
REQ-010 The block SHALL have ports rsv, rsv_addr  input  1/ADDR_W  reserve request marking a register busy.
REQ-011 The block SHALL have ports rout1, rout2  output  DATA_W  read data for rs, rt.
REQ-012 The block SHALL have ports busy1, busy2  output  1  scoreboard busy bit for rs, rt.
REQ-013 The block SHALL have port busy_cnt  output  ADDR_W+1  number of registers currently busy.

Function
REQ-014 Reads SHALL be combinational: rout1 = reg[rs], rout2 = reg[rt], zero latency.
REQ-015 Writes SHALL commit on the rising clk edge when the enable is high; data is visible via array read in the following cycle.
REQ-016 With BYPASS=1, a read address matching an enabled write address SHALL return that write's data in the same cycle.
REQ-017 When wr and wr2 target the same address in one cycle, wr2 data SHALL win for both commit and bypass.
REQ-018 With ZERO_R0=1, address 0 SHALL read 0, never bypass, never become busy, and writes to it SHALL be discarded.
REQ-019 rsv SHALL set busy[rsv_addr] on the clock edge; a wr2 write SHALL clear busy[rd2] on the clock edge.
REQ-020 The primary port wr SHALL NOT alter any busy bit.
REQ-021 When rsv and wr2 hit the same address in one cycle, set SHALL win (busy stays 1).
REQ-022 rsv on an already-busy register SHALL leave it busy with no count change; wr2 to a non-busy register SHALL write data with no count change.
REQ-023 busy1/busy2 SHALL reflect registered busy bits, with no bypass of same-cycle rsv or clear.
REQ-024 busy_cnt SHALL be a registered count equal to the population of busy bits after every edge, covering simultaneous +1/-1 (net 0) and never wrapping (max 2**ADDR_W, or 2**ADDR_W-1 with ZERO_R0).
REQ-025 Out-of-range behaviour SHALL be impossible: all addresses span the full 2**ADDR_W depth.

Reset
REQ-026 rst low SHALL asynchronously clear all registers to 0, all busy bits to 0 and busy_cnt to 0.
REQ-027 During reset rout1/rout2 SHALL read 0, busy1/busy2 0; writes and reserves SHALL be ignored.
REQ-028 Reset deassertion SHALL be synchronised externally; the first accepted write is on the first rising edge with rst high.
REQ-029 Reset mid-operation SHALL drop all pending reservations with no residual state.

Structure
REQ-030 Default widths and the busy-count width function SHALL live in shared package rf_pkg.
REQ-031 The scoreboard (busy bits + counter) SHALL be a sub-module rf_scoreboard; the data array and bypass SHALL remain in reg_file_sb.

Verification
REQ-032 Reset: hold rst=0 over 2 edges with wr=1, rd=5, rw=16'hFFFF -> all reads 0, busy_cnt=0; after release, read reg 5 = 0.
REQ-033 Write/read: wr=1, rd=10, rw=16'h1B50, then rs=10 -> rout1=16'h1B50 next cycle; same-cycle with rs=10 -> 16'h1B50 via bypass (BYPASS=1), old value 0 (BYPASS=0).
REQ-034 Dual-write collision: wr rd=3 rw=16'h2D50 and wr2 rd2=3 rw2=16'hF612 same cycle -> reg 3 = 16'hF612.
REQ-035 Scoreboard: rsv 9 then rsv 4 -> busy_cnt=2, busy1=1 for rs=9; wr2 rd2=9 rw2=16'h0512 -> busy_cnt=1, rout1=16'h0512; rsv 4 + wr2 4 same cycle -> busy[4]=1, busy_cnt=1.
REQ-036 R0: wr rd=0 rw=16'h4512, rsv 0 -> rout1(rs=0)=0, busy_cnt unchanged.
REQ-037 Full scoreboard: reserve all 15 non-zero registers -> busy_cnt=15; repeat rsv 15 -> stays 15; assert rst mid-sequence -> busy_cnt=0 immediately.
